traffic_phase_controller: RTL and testbench

- Demand-actuated, N-way traffic signal controller with parametrised phase durations.
- Grants green to one direction at a time, round-robin among directions with latched vehicle demand.
- Every change of direction passes through yellow and a configurable all-red clearance.
- Successor to the fixed two-way NS/EW sequencer; drives the signal-head output stage, which uses the same 2-bit light encoding.

---
 rtl/traffic_pkg.sv | 24 ++
 rtl/traffic_rr_pick.sv | 24 ++
 rtl/traffic_phase_controller.sv | 126 ++++++++++++
 tb/tb_traffic_phase_controller.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared light encoding, phase enumeration and counter sizing for the
// traffic signal controller family.
package traffic_pkg;

    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_GREEN  = 2'b10;

    typedef enum logic [1:0] {
        PH_GREEN,
        PH_YELLOW,
        PH_ALLRED
    } phase_t;

    // Width of a counter that must reach the largest of the phase durations.
    function automatic int cnt_width(input int g, input int y, input int a);
        int m;
        m = g;
        if (y > m) m = y;
        if (a > m) m = a;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/traffic_rr_pick.sv
// Round-robin successor pick: first set pending bit after active_dir,
// wrapping, with active_dir itself considered last.
module traffic_rr_pick #(
    parameter int NUM_DIRS = 4
) (
    input  logic [NUM_DIRS-1:0]         pending,
    input  logic [$clog2(NUM_DIRS)-1:0] active_dir,
    output logic [$clog2(NUM_DIRS)-1:0] next_dir
);
    localparam int DW = $clog2(NUM_DIRS);

    int idx;

    // Scan from farthest to nearest so the nearest set bit wins.
    always_comb begin
        next_dir = active_dir;
        idx      = 0;
        for (int k = NUM_DIRS; k >= 1; k--) begin
            idx = (int'(active_dir) + k) % NUM_DIRS;
            if (pending[idx]) next_dir = DW'(idx);
        end
    end

endmodule

// File: rtl/traffic_phase_controller.sv
// Demand-actuated N-way signal controller: one green direction at a time,
// round-robin over latched demand, yellow and optional all-red between.
//
//   state     | meaning
//   PH_GREEN  | active_dir green; counts up to minimum green then holds
//   PH_YELLOW | active_dir yellow for YELLOW_CYCLES
//   PH_ALLRED | every head red for ALLRED_CYCLES (skipped when 0)
module traffic_phase_controller
    import traffic_pkg::*;
#(
    parameter int NUM_DIRS      = 4,
    parameter int GREEN_CYCLES  = 5,
    parameter int YELLOW_CYCLES = 2,
    parameter int ALLRED_CYCLES = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_DIRS-1:0]         car_req,
    output logic [2*NUM_DIRS-1:0]       lights,
    output logic [$clog2(NUM_DIRS)-1:0] active_dir,
    output logic                        green_start,
    output logic [NUM_DIRS-1:0]         pending
);
    localparam int DW = $clog2(NUM_DIRS);
    localparam int CW = cnt_width(GREEN_CYCLES, YELLOW_CYCLES, ALLRED_CYCLES);
    localparam logic [CW-1:0] G_LAST = CW'(GREEN_CYCLES - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(YELLOW_CYCLES - 1);
    localparam logic [CW-1:0] A_LAST = (ALLRED_CYCLES > 0) ? CW'(ALLRED_CYCLES - 1) : '0;

    phase_t              phase_q, phase_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DW-1:0]       dir_q, dir_d, next_dir;
    logic [NUM_DIRS-1:0] pend_q, pend_d, req_mask, own_mask;
    logic                gs_q, gs_d, enter_green;

    traffic_rr_pick #(.NUM_DIRS(NUM_DIRS)) u_pick (
        .pending    (pend_q),
        .active_dir (dir_q),
        .next_dir   (next_dir)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= PH_GREEN;
            cnt_q   <= '0;
            dir_q   <= '0;
            pend_q  <= '0;
            gs_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            gs_q    <= gs_d;
        end
    end

    always_comb begin
        phase_d          = phase_q;
        cnt_d            = cnt_q;
        dir_d            = dir_q;
        own_mask         = '0;
        own_mask[dir_q]  = 1'b1;
        req_mask         = car_req;
        if (phase_q == PH_GREEN) req_mask[dir_q] = 1'b0;
        pend_d           = pend_q | req_mask;

        case (phase_q)
            PH_GREEN: begin
                if (cnt_q == G_LAST) begin
                    if (|(pend_q & ~own_mask)) begin
                        phase_d = PH_YELLOW;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PH_YELLOW: begin
                if (cnt_q == Y_LAST) begin
                    cnt_d = '0;
                    if (ALLRED_CYCLES == 0) begin
                        phase_d = PH_GREEN;
                        dir_d   = next_dir;
                    end else begin
                        phase_d = PH_ALLRED;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PH_ALLRED: begin
                if (cnt_q == A_LAST) begin
                    cnt_d   = '0;
                    phase_d = PH_GREEN;
                    dir_d   = next_dir;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                phase_d = PH_GREEN;
                cnt_d   = '0;
            end
        endcase

        // Clearing on green entry takes priority over a same-cycle request.
        enter_green = (phase_d == PH_GREEN) && (phase_q != PH_GREEN);
        if (enter_green) pend_d[dir_d] = 1'b0;
        gs_d = enter_green;
    end

    always_comb begin
        lights = '0;
        case (phase_q)
            PH_GREEN:  lights[2*int'(dir_q) +: 2] = LIGHT_GREEN;
            PH_YELLOW: lights[2*int'(dir_q) +: 2] = LIGHT_YELLOW;
            default:   lights = '0;
        endcase
    end

    assign active_dir  = dir_q;
    assign green_start = gs_q;
    assign pending     = pend_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller: a 4-way instance with all-red
// clearance and a 2-way instance without it.
module tb_traffic_phase_controller;

    logic       clk;
    logic       reset;
    logic [3:0] car_req;
    logic [7:0] lights;
    logic [1:0] active_dir;
    logic       green_start;
    logic [3:0] pending;

    logic [1:0] car_req_b;
    logic [3:0] lights_b;
    logic [0:0] active_dir_b;
    logic       green_start_b;
    logic [1:0] pending_b;

    int n_cmp = 0;
    int n_err = 0;

    traffic_phase_controller #(
        .NUM_DIRS(4), .GREEN_CYCLES(5), .YELLOW_CYCLES(2), .ALLRED_CYCLES(1)
    ) dut (
        .clk(clk), .reset(reset), .car_req(car_req), .lights(lights),
        .active_dir(active_dir), .green_start(green_start), .pending(pending)
    );

    traffic_phase_controller #(
        .NUM_DIRS(2), .GREEN_CYCLES(5), .YELLOW_CYCLES(2), .ALLRED_CYCLES(0)
    ) dut_b (
        .clk(clk), .reset(reset), .car_req(car_req_b), .lights(lights_b),
        .active_dir(active_dir_b), .green_start(green_start_b), .pending(pending_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int nonred(input logic [7:0] l);
        int n = 0;
        for (int i = 0; i < 4; i++) if (l[2*i +: 2] != 2'b00) n++;
        return n;
    endfunction

    function automatic bit any_green(input logic [7:0] l);
        bit g = 0;
        for (int i = 0; i < 4; i++) if (l[2*i +: 2] == 2'b10) g = 1;
        return g;
    endfunction

    function automatic logic [3:0] exp_b(input int i);
        int p = i % 14;
        if (p < 2) return 4'b0001;
        if (p < 7) return 4'b1000;
        if (p < 9) return 4'b0100;
        return 4'b0010;
    endfunction

    initial begin
        int         pulses;
        int         last_cyc;
        int         gcnt;
        bit         found;
        logic [1:0] exp_order [5];
        exp_order = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        reset = 1'b1;
        car_req = '0;
        car_req_b = '0;
        repeat (3) @(negedge clk);
        check("rst_lights", 32'(lights), 32'h02);
        check("rst_dir", 32'(active_dir), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_gs", 32'(green_start), 0);
        reset = 1'b0;

        // Idle: dir0 rests green, no green_start.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_lights", 32'(lights), 32'h02);
            check("idle_dir", 32'(active_dir), 0);
            check("idle_gs", 32'(green_start), 0);
        end
        check("idle_pending", 32'(pending), 0);

        // Single pulse demand on dir2.
        car_req = 4'b0100;
        @(negedge clk);
        car_req = '0;
        check("t2_pend_set", 32'(pending), 32'h4);
        check("t2_still_green", 32'(lights), 32'h02);
        @(negedge clk);
        check("t2_y1", 32'(lights), 32'h01);
        check("t2_y1_dir", 32'(active_dir), 0);
        @(negedge clk);
        check("t2_y2", 32'(lights), 32'h01);
        @(negedge clk);
        check("t2_allred", 32'(lights), 32'h00);
        check("t2_allred_gs", 32'(green_start), 0);
        @(negedge clk);
        check("t2_green", 32'(lights), 32'h20);
        check("t2_dir", 32'(active_dir), 2);
        check("t2_gs", 32'(green_start), 1);
        check("t2_pend_clr", 32'(pending), 0);
        @(negedge clk);
        check("t2_gs_once", 32'(green_start), 0);

        // Own-direction demand while green is ignored.
        car_req = 4'b0100;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("t4_pending", 32'(pending), 0);
            check("t4_lights", 32'(lights), 32'h20);
        end
        car_req = '0;
        repeat (3) @(negedge clk);
        check("t4_rest_dir", 32'(active_dir), 2);

        // All directions held: strict round robin, 8 cycles per slot.
        reset = 1'b1;
        car_req = 4'b1111;
        @(negedge clk);
        check("t3_rst_lights", 32'(lights), 32'h02);
        reset = 1'b0;
        pulses = 0;
        last_cyc = 0;
        gcnt = 0;
        for (int cyc = 0; cyc < 200 && pulses < 5; cyc++) begin
            @(negedge clk);
            check("t3_excl", 32'(nonred(lights) <= 1), 1);
            if (green_start) begin
                check("t3_order", 32'(active_dir), 32'(exp_order[pulses]));
                if (pulses > 0) begin
                    check("t3_interval", 32'(cyc - last_cyc), 8);
                    check("t3_green_len", 32'(gcnt), 5);
                end
                pulses++;
                last_cyc = cyc;
                gcnt = 0;
            end
            if (any_green(lights)) gcnt++;
        end
        check("t3_pulses", 32'(pulses), 5);

        // Reset during dir1 yellow.
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (lights == 8'h04) found = 1;
        end
        check("t6_saw_yellow", 32'(found), 1);
        #2 reset = 1'b1;
        #1;
        check("t6_async_lights", 32'(lights), 32'h02);
        check("t6_async_dir", 32'(active_dir), 0);
        check("t6_async_pend", 32'(pending), 0);
        check("t6_async_gs", 32'(green_start), 0);
        car_req = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (8) begin
            @(negedge clk);
            check("t6_rest", 32'(lights), 32'h02);
        end
        check("t6_pend", 32'(pending), 0);
        car_req = 4'b0010;
        @(negedge clk);
        car_req = '0;
        check("t6_pend_set", 32'(pending), 32'h2);
        @(negedge clk);
        check("t6_y1", 32'(lights), 32'h01);
        @(negedge clk);
        check("t6_y2", 32'(lights), 32'h01);
        @(negedge clk);
        check("t6_allred", 32'(lights), 32'h00);
        @(negedge clk);
        check("t6_green", 32'(lights), 32'h08);
        check("t6_dir", 32'(active_dir), 1);
        check("t6_gs", 32'(green_start), 1);

        // Two-way, no all-red: green 5 / yellow 2 alternating.
        reset = 1'b1;
        car_req = '0;
        car_req_b = 2'b11;
        @(negedge clk);
        check("t5_rst_lights", 32'(lights_b), 32'h2);
        reset = 1'b0;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (lights_b == 4'b0001) found = 1;
        end
        check("t5_saw_yellow", 32'(found), 1);
        for (int i = 0; i < 28; i++) begin
            check("t5_pattern", 32'(lights_b), 32'(exp_b(i)));
            @(negedge clk);
        end
        car_req_b = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
